rooth_clint: RTL and testbench

- Core-local interrupt/exception controller.
- Detects ECALL/EBREAK/MRET in the EX stage and external interrupt requests.
- Sequences the machine-mode CSR updates (mepc, mstatus, mcause) through the CSR write port.
- Drives the pipeline-controller interrupt interface: clint_hold_flag_o, clint_int_addr_o, clint_int_assert_o. The pipeline controller stalls all stages on hold, and on assert redirects PC and refreshes every stage.

---
 rtl/rooth_clint.sv | 146 ++++++++++++++
 tb/tb_rooth_clint.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rooth_clint.sv
// Core-local interrupt controller: detects ECALL/EBREAK/MRET and external interrupts in EX,
// sequences the machine-mode CSR updates and issues a one-cycle PC redirect to the pipeline.
module rooth_clint #(
    parameter int unsigned       CPU_WIDTH    = 32,
    parameter logic [31:0]       INT_CAUSE    = 32'h8000_000B,
    parameter logic [11:0]       ADDR_MSTATUS = 12'h300,
    parameter logic [11:0]       ADDR_MEPC    = 12'h341,
    parameter logic [11:0]       ADDR_MCAUSE  = 12'h342
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           int_flag_i,
    input  logic [31:0]          inst_i,
    input  logic [CPU_WIDTH-1:0] inst_addr_i,
    input  logic                 inst_valid_i,
    input  logic                 hold_flag_i,
    input  logic [CPU_WIDTH-1:0] csr_mtvec_i,
    input  logic [CPU_WIDTH-1:0] csr_mepc_i,
    input  logic [CPU_WIDTH-1:0] csr_mstatus_i,
    output logic                 csr_we_o,
    output logic [11:0]          csr_waddr_o,
    output logic [CPU_WIDTH-1:0] csr_wdata_o,
    output logic                 clint_hold_flag_o,
    output logic [CPU_WIDTH-1:0] clint_int_addr_o,
    output logic                 clint_int_assert_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    typedef enum logic [2:0] {
        IDLE,
        WR_MEPC,
        WR_MSTATUS,
        WR_MCAUSE,
        RET_MSTATUS,
        ASSERT
    } state_t;

    state_t                 state_q;
    logic [CPU_WIDTH-1:0]   cause_q;
    logic                   we_q;
    logic [11:0]            waddr_q;
    logic [CPU_WIDTH-1:0]   wdata_q;
    logic                   assert_q;
    logic [CPU_WIDTH-1:0]   int_addr_q;

    logic                   can_detect;
    logic                   is_ecall;
    logic                   is_ebreak;
    logic                   is_mret;
    logic                   sync_trap;
    logic                   async_trap;
    logic                   mret_req;
    logic [CPU_WIDTH-1:0]   mstatus_trap;
    logic [CPU_WIDTH-1:0]   mstatus_ret;

    always_comb begin
        is_ecall   = (inst_i == INST_ECALL);
        is_ebreak  = (inst_i == INST_EBREAK);
        is_mret    = (inst_i == INST_MRET);
        // Gated by rst_n so the hold output also drops immediately while reset is held.
        can_detect = rst_n && (state_q == IDLE) && !hold_flag_i && inst_valid_i;
        sync_trap  = can_detect && (is_ecall || is_ebreak);
        mret_req   = can_detect && is_mret;
        async_trap = can_detect && !is_ecall && !is_ebreak && !is_mret
                     && (int_flag_i != '0) && csr_mstatus_i[3];

        mstatus_trap    = csr_mstatus_i;
        mstatus_trap[7] = csr_mstatus_i[3];
        mstatus_trap[3] = 1'b0;
        mstatus_ret     = csr_mstatus_i;
        mstatus_ret[3]  = csr_mstatus_i[7];
        mstatus_ret[7]  = 1'b1;
    end

    // Outputs are registered on the transition into each state, so they line up with that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cause_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            assert_q   <= 1'b0;
            int_addr_q <= '0;
        end else begin
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            assert_q   <= 1'b0;
            int_addr_q <= '0;
            case (state_q)
                IDLE: begin
                    if (sync_trap || async_trap) begin
                        state_q <= WR_MEPC;
                        cause_q <= async_trap ? CPU_WIDTH'(INT_CAUSE)
                                 : (is_ecall ? CPU_WIDTH'(11) : CPU_WIDTH'(3));
                        we_q    <= 1'b1;
                        waddr_q <= ADDR_MEPC;
                        wdata_q <= inst_addr_i;
                    end else if (mret_req) begin
                        state_q <= RET_MSTATUS;
                        we_q    <= 1'b1;
                        waddr_q <= ADDR_MSTATUS;
                        wdata_q <= mstatus_ret;
                    end
                end
                WR_MEPC: begin
                    state_q <= WR_MSTATUS;
                    we_q    <= 1'b1;
                    waddr_q <= ADDR_MSTATUS;
                    wdata_q <= mstatus_trap;
                end
                WR_MSTATUS: begin
                    state_q <= WR_MCAUSE;
                    we_q    <= 1'b1;
                    waddr_q <= ADDR_MCAUSE;
                    wdata_q <= cause_q;
                end
                WR_MCAUSE: begin
                    state_q    <= ASSERT;
                    assert_q   <= 1'b1;
                    int_addr_q <= csr_mtvec_i;
                end
                RET_MSTATUS: begin
                    state_q    <= ASSERT;
                    assert_q   <= 1'b1;
                    int_addr_q <= csr_mepc_i;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign csr_we_o           = we_q;
    assign csr_waddr_o        = waddr_q;
    assign csr_wdata_o        = wdata_q;
    assign clint_int_assert_o = assert_q;
    assign clint_int_addr_o   = int_addr_q;
    assign clint_hold_flag_o  = sync_trap || async_trap || mret_req || (state_q != IDLE);

endmodule

// File: tb/tb_rooth_clint.sv
// Directed-vector bench for rooth_clint: trap, MRET, interrupt masking, hold deferral, reset mid-trap.
module tb_rooth_clint;

    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] MRET  = 32'h3020_0073;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [7:0]  int_flag_i;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        inst_valid_i;
    logic        hold_flag_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic [31:0] csr_mstatus_i;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        clint_hold_flag_o;
    logic [31:0] clint_int_addr_o;
    logic        clint_int_assert_o;

    int unsigned total;
    int unsigned bad;

    rooth_clint #(
        .CPU_WIDTH (32),
        .INT_CAUSE (32'h8000_000B)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .int_flag_i         (int_flag_i),
        .inst_i             (inst_i),
        .inst_addr_i        (inst_addr_i),
        .inst_valid_i       (inst_valid_i),
        .hold_flag_i        (hold_flag_i),
        .csr_mtvec_i        (csr_mtvec_i),
        .csr_mepc_i         (csr_mepc_i),
        .csr_mstatus_i      (csr_mstatus_i),
        .csr_we_o           (csr_we_o),
        .csr_waddr_o        (csr_waddr_o),
        .csr_wdata_o        (csr_wdata_o),
        .clint_hold_flag_o  (clint_hold_flag_o),
        .clint_int_addr_o   (clint_int_addr_o),
        .clint_int_assert_o (clint_int_assert_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Checks every output for one cycle; waddr/wdata are only compared when a write is expected.
    task automatic expect_cyc(input string tag, input logic hold, input logic we,
                              input logic [11:0] waddr, input logic [31:0] wdata,
                              input logic asrt, input logic [31:0] addr);
        #1;
        chk({tag, ".hold"}, 32'(clint_hold_flag_o), 32'(hold));
        chk({tag, ".we"}, 32'(csr_we_o), 32'(we));
        if (we) begin
            chk({tag, ".waddr"}, 32'(csr_waddr_o), 32'(waddr));
            chk({tag, ".wdata"}, csr_wdata_o, wdata);
        end
        chk({tag, ".assert"}, 32'(clint_int_assert_o), 32'(asrt));
        chk({tag, ".iaddr"}, clint_int_addr_o, addr);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n         = 1'b0;
        int_flag_i    = 8'h00;
        inst_i        = NOP;
        inst_addr_i   = 32'h0;
        inst_valid_i  = 1'b1;
        hold_flag_i   = 1'b0;
        csr_mtvec_i   = 32'h200;
        csr_mepc_i    = 32'h0;
        csr_mstatus_i = 32'h08;

        // Reset state
        tick;
        expect_cyc("reset", 0, 0, 12'h0, 32'h0, 0, 32'h0);
        tick;
        rst_n = 1'b1;
        tick;
        expect_cyc("idle", 0, 0, 12'h0, 32'h0, 0, 32'h0);

        // ECALL at 0x100, mtvec 0x200, mstatus 0x08
        tick;
        inst_i = ECALL; inst_addr_i = 32'h100;
        expect_cyc("ecall.T0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
        tick; inst_i = NOP;
        expect_cyc("ecall.T1", 1, 1, 12'h341, 32'h100, 0, 32'h0);
        tick;
        expect_cyc("ecall.T2", 1, 1, 12'h300, 32'h80, 0, 32'h0);
        tick; csr_mstatus_i = 32'h80;
        expect_cyc("ecall.T3", 1, 1, 12'h342, 32'd11, 0, 32'h0);
        tick;
        expect_cyc("ecall.T4", 1, 0, 12'h0, 32'h0, 1, 32'h200);
        tick;
        expect_cyc("ecall.T5", 0, 0, 12'h0, 32'h0, 0, 32'h0);

        // MRET with mstatus 0x80, mepc 0x104
        tick;
        csr_mepc_i = 32'h104; inst_i = MRET;
        expect_cyc("mret.T0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
        tick; inst_i = NOP;
        expect_cyc("mret.T1", 1, 1, 12'h300, 32'h88, 0, 32'h0);
        tick; csr_mstatus_i = 32'h88;
        expect_cyc("mret.T2", 1, 0, 12'h0, 32'h0, 1, 32'h104);
        tick;
        expect_cyc("mret.T3", 0, 0, 12'h0, 32'h0, 0, 32'h0);

        // Interrupt masked by MIE=0, then taken once MIE=1
        tick;
        csr_mstatus_i = 32'h80; int_flag_i = 8'h01;
        expect_cyc("mask.c0", 0, 0, 12'h0, 32'h0, 0, 32'h0);
        tick;
        expect_cyc("mask.c1", 0, 0, 12'h0, 32'h0, 0, 32'h0);
        tick;
        csr_mstatus_i = 32'h08; inst_addr_i = 32'h40;
        expect_cyc("irq.T0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
        tick;
        expect_cyc("irq.T1", 1, 1, 12'h341, 32'h40, 0, 32'h0);
        tick;
        expect_cyc("irq.T2", 1, 1, 12'h300, 32'h80, 0, 32'h0);
        tick; csr_mstatus_i = 32'h80;
        expect_cyc("irq.T3", 1, 1, 12'h342, 32'h8000_000B, 0, 32'h0);
        tick;
        expect_cyc("irq.T4", 1, 0, 12'h0, 32'h0, 1, 32'h200);
        tick;
        expect_cyc("irq.T5", 0, 0, 12'h0, 32'h0, 0, 32'h0);

        // Deferred by hold_flag_i for 3 cycles, then reset during WR_MSTATUS
        tick;
        csr_mstatus_i = 32'h08; hold_flag_i = 1'b1; inst_addr_i = 32'h60;
        for (int i = 0; i < 3; i++) begin
            expect_cyc("defer", 0, 0, 12'h0, 32'h0, 0, 32'h0);
            tick;
        end
        hold_flag_i = 1'b0;
        expect_cyc("defer.T0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
        tick;
        expect_cyc("defer.T1", 1, 1, 12'h341, 32'h60, 0, 32'h0);
        tick;
        expect_cyc("defer.T2", 1, 1, 12'h300, 32'h80, 0, 32'h0);
        int_flag_i = 8'h00;
        rst_n = 1'b0;
        expect_cyc("rstmid", 0, 0, 12'h0, 32'h0, 0, 32'h0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            expect_cyc("rstpost", 0, 0, 12'h0, 32'h0, 0, 32'h0);
        end

        // ECALL plus interrupt: sync cause wins, no back-to-back async trap
        tick;
        csr_mstatus_i = 32'h08; int_flag_i = 8'h01; inst_i = ECALL; inst_addr_i = 32'h80;
        expect_cyc("both.T0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
        tick; inst_i = NOP;
        expect_cyc("both.T1", 1, 1, 12'h341, 32'h80, 0, 32'h0);
        tick;
        expect_cyc("both.T2", 1, 1, 12'h300, 32'h80, 0, 32'h0);
        tick; csr_mstatus_i = 32'h80;
        expect_cyc("both.T3", 1, 1, 12'h342, 32'd11, 0, 32'h0);
        tick;
        expect_cyc("both.T4", 1, 0, 12'h0, 32'h0, 1, 32'h200);
        tick;
        expect_cyc("both.T5", 0, 0, 12'h0, 32'h0, 0, 32'h0);
        tick;
        expect_cyc("both.T6", 0, 0, 12'h0, 32'h0, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
